// File: rtl/prbs_seq_ctrl_pkg.sv
// prbs_pkg: shared definitions for the PRBS sequencer.
//   prbs_state_t      - controller FSM states (explicit legacy encodings)
//   PRBS_DEFAULT_POLY - default 7-bit feedback tap mask (x^7 + x^6 + 1)
//   clog2()           - ceil(log2(value)), used to size the bit counter
package prbs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    OUT  = 2'd3
  } prbs_state_t;

  localparam logic [6:0] PRBS_DEFAULT_POLY = 7'b1100000;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_seq_ctrl_if.sv
// prbs_seq_ctrl_if: command and word-stream bundle of the PRBS sequencer.
//   master - config/CSR side plus data consumer (drives cmd_*, abort, word_ready)
//   slave  - sequencer side (drives cmd_ready, word_*, busy, err)
interface prbs_seq_ctrl_if #(
  parameter int LFSR_WIDTH = 7,
  parameter int WORD_W     = 8,
  parameter int CNT_W      = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [LFSR_WIDTH-1:0] cmd_seed;
  logic [CNT_W-1:0]      cmd_nwords;
  logic                  abort;
  logic                  word_valid;
  logic                  word_ready;
  logic [WORD_W-1:0]     word_data;
  logic                  word_last;
  logic                  busy;
  logic                  err;

  modport master (
    output cmd_valid, cmd_seed, cmd_nwords, abort, word_ready,
    input  cmd_ready, word_valid, word_data, word_last, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_seed, cmd_nwords, abort, word_ready,
    output cmd_ready, word_valid, word_data, word_last, busy, err
  );
endinterface

// File: rtl/prbs_seq_ctrl_lfsr_core.sv
// prbs_lfsr_core: Fibonacci LFSR with synchronous load and enable.
//   clk, reset_n - clock, asynchronous active-low reset (state clears to 0)
//   i_ld         - load i_seed into the state (wins over i_en)
//   i_en         - advance one step: shift left, feedback into LSB
//   i_seed       - load value
//   o_dout       - serial output, the current state MSB
module prbs_lfsr_core #(
  parameter int                WIDTH      = 7,
  parameter logic [WIDTH-1:0]  POLYNOMIAL = 7'b1100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_ld,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_seed,
  output logic             o_dout
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
    end else if (i_ld) begin
      r_state <= i_seed;
    end else if (i_en) begin
      r_state <= {r_state[WIDTH-2:0], ^(r_state & POLYNOMIAL)};
    end
  end

  assign o_dout = r_state[WIDTH-1];

endmodule

// File: rtl/prbs_seq_ctrl.sv
// prbs_seq_ctrl: command-driven PRBS word generator.
//   clk, reset_n - clock, asynchronous active-low reset
//   bus (slave)  - cmd_valid/cmd_ready/cmd_seed/cmd_nwords command port,
//                  abort, word_valid/word_ready/word_data/word_last stream,
//                  busy (not IDLE) and err (one-cycle reject pulse)
// A command loads the seed into the LFSR, then each word is built from
// WORD_W serial bits (first bit lands in the MSB) and held until consumed.
// The LFSR is frozen while a word waits, so the bit stream is continuous
// across the words of one command.
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int                    LFSR_WIDTH      = 7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL = LFSR_WIDTH'(PRBS_DEFAULT_POLY),
  parameter int                    WORD_W          = 8,
  parameter int                    CNT_W           = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  prbs_seq_ctrl_if.slave  bus
);

  localparam int unsigned           BIT_CNT_W = clog2(WORD_W + 1);
  localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(WORD_W - 1);

  prbs_state_t           r_state;
  logic [LFSR_WIDTH-1:0] r_seed;
  logic [CNT_W-1:0]      r_count;
  logic [BIT_CNT_W-1:0]  r_bitcnt;
  logic [WORD_W-1:0]     r_word;
  logic                  r_err;

  logic w_ld;
  logic w_en;
  logic w_dout;
  logic w_last;

  assign w_ld   = (r_state == LOAD);
  assign w_en   = (r_state == RUN);
  assign w_last = (r_count == CNT_W'(1));

  prbs_lfsr_core #(
    .WIDTH      (LFSR_WIDTH),
    .POLYNOMIAL (LFSR_POLYNOMIAL)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_ld    (w_ld),
    .i_en    (w_en),
    .i_seed  (r_seed),
    .o_dout  (w_dout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_seed   <= '0;
      r_count  <= '0;
      r_bitcnt <= '0;
      r_word   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_seed == '0 || bus.cmd_nwords == '0) begin
              r_err <= 1'b1;
            end else begin
              r_seed   <= bus.cmd_seed;
              r_count  <= bus.cmd_nwords;
              r_bitcnt <= '0;
              r_state  <= LOAD;
            end
          end
        end
        LOAD: begin
          r_state <= bus.abort ? IDLE : RUN;
        end
        RUN: begin
          if (bus.abort) begin
            r_bitcnt <= '0;
            r_state  <= IDLE;
          end else begin
            r_word <= {r_word[WORD_W-2:0], w_dout};
            if (r_bitcnt == BIT_LAST) begin
              r_bitcnt <= '0;
              r_state  <= OUT;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        OUT: begin
          // A handshake coinciding with abort still consumes the word.
          if (bus.word_ready) begin
            r_count <= r_count - 1'b1;
            r_state <= (w_last || bus.abort) ? IDLE : RUN;
          end else if (bus.abort) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (r_state == IDLE);
  assign bus.busy       = (r_state != IDLE);
  assign bus.word_valid = (r_state == OUT);
  assign bus.word_last  = (r_state == OUT) && w_last;
  assign bus.word_data  = r_word;
  assign bus.err        = r_err;

endmodule
